// File: rtl/ctrl_pipe_hazard_if.sv
// Control-pipeline bundle: decoded ID fields in, staged EX/MEM/WB control,
// stall and forwarding selects out.
interface ctrl_pipe_hazard_if #(
   parameter int unsigned REG_AW = 5
);
   logic              id_valid;
   logic              id_reg_dst;
   logic [1:0]        id_jump;
   logic              id_branch;
   logic [1:0]        id_mem_read;
   logic              id_mem_to_reg;
   logic [1:0]        id_alu_op;
   logic [1:0]        id_mem_write;
   logic              id_alu_src;
   logic              id_reg_write;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [REG_AW-1:0] id_rd;
   logic              ex_flush;

   logic              stall;
   logic              ex_valid;
   logic              ex_branch;
   logic              ex_alu_src;
   logic [1:0]        ex_jump;
   logic [1:0]        ex_alu_op;
   logic [REG_AW-1:0] ex_rs;
   logic [REG_AW-1:0] ex_rt;
   logic [1:0]        forward_a;
   logic [1:0]        forward_b;
   logic [1:0]        mem_mem_read;
   logic [1:0]        mem_mem_write;
   logic              mem_reg_write;
   logic              mem_mem_to_reg;
   logic [REG_AW-1:0] mem_dest;
   logic              wb_reg_write;
   logic              wb_mem_to_reg;
   logic [REG_AW-1:0] wb_dest;

   // Decoder / datapath side.
   modport master (
      output id_valid, id_reg_dst, id_jump, id_branch, id_mem_read, id_mem_to_reg,
             id_alu_op, id_mem_write, id_alu_src, id_reg_write, id_rs, id_rt, id_rd,
             ex_flush,
      input  stall, ex_valid, ex_branch, ex_alu_src, ex_jump, ex_alu_op, ex_rs, ex_rt,
             forward_a, forward_b, mem_mem_read, mem_mem_write, mem_reg_write,
             mem_mem_to_reg, mem_dest, wb_reg_write, wb_mem_to_reg, wb_dest
   );

   // Hazard/control pipeline side.
   modport slave (
      input  id_valid, id_reg_dst, id_jump, id_branch, id_mem_read, id_mem_to_reg,
             id_alu_op, id_mem_write, id_alu_src, id_reg_write, id_rs, id_rt, id_rd,
             ex_flush,
      output stall, ex_valid, ex_branch, ex_alu_src, ex_jump, ex_alu_op, ex_rs, ex_rt,
             forward_a, forward_b, mem_mem_read, mem_mem_write, mem_reg_write,
             mem_mem_to_reg, mem_dest, wb_reg_write, wb_mem_to_reg, wb_dest
   );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline EX/MEM/WB with load-use stall, flush bubbles and EX forwarding selects.
module ctrl_pipe_hazard #(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned LINK_REG = 31
) (
   input logic               clk,
   input logic               reset_n,
   ctrl_pipe_hazard_if.slave bus_io
);

   typedef struct packed {
      logic              valid;
      logic              branch;
      logic              alu_src;
      logic [1:0]        jump;
      logic [1:0]        alu_op;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [1:0]        mem_read;
      logic [1:0]        mem_write;
      logic              reg_write;
      logic              mem_to_reg;
      logic [REG_AW-1:0] dest;
   } ex_ctrl_t;

   typedef struct packed {
      logic [1:0]        mem_read;
      logic [1:0]        mem_write;
      logic              reg_write;
      logic              mem_to_reg;
      logic [REG_AW-1:0] dest;
   } mem_ctrl_t;

   typedef struct packed {
      logic              reg_write;
      logic              mem_to_reg;
      logic [REG_AW-1:0] dest;
   } wb_ctrl_t;

   ex_ctrl_t          ex_d, ex_q;
   mem_ctrl_t         mem_q;
   wb_ctrl_t          wb_q;
   logic [REG_AW-1:0] id_dest;
   logic              id_reg_write;
   logic              uses_rt;
   logic              stall;
   logic              bubble;
   logic [1:0]        fwd_a, fwd_b;

   // Destination and write enable of the ID instruction; r0 is never written.
   always_comb begin
      id_dest = bus_io.id_reg_dst ? bus_io.id_rd : bus_io.id_rt;
      if (bus_io.id_jump == 2'b10) id_dest = REG_AW'(LINK_REG);
      id_reg_write = (bus_io.id_reg_write | (bus_io.id_jump == 2'b10)) & (id_dest != '0);
   end

   // Load-use detection; a flush kills the consumer, so it never stalls.
   always_comb begin
      uses_rt = ~bus_io.id_alu_src | (bus_io.id_mem_write != 2'b00) | bus_io.id_branch;
      stall   = ex_q.valid & (ex_q.mem_read != 2'b00) & (ex_q.dest != '0) &
                bus_io.id_valid & ~bus_io.ex_flush &
                ((ex_q.dest == bus_io.id_rs) | (uses_rt & (ex_q.dest == bus_io.id_rt)));
      bubble  = bus_io.ex_flush | stall | ~bus_io.id_valid;
   end

   // Next EX contents; a bubble is all-zero so garbage ID fields never get captured.
   always_comb begin
      ex_d = '0;
      if (!bubble) begin
         ex_d.valid      = 1'b1;
         ex_d.branch     = bus_io.id_branch;
         ex_d.alu_src    = bus_io.id_alu_src;
         ex_d.jump       = bus_io.id_jump;
         ex_d.alu_op     = bus_io.id_alu_op;
         ex_d.rs         = bus_io.id_rs;
         ex_d.rt         = bus_io.id_rt;
         ex_d.mem_read   = bus_io.id_mem_read;
         ex_d.mem_write  = bus_io.id_mem_write;
         ex_d.reg_write  = id_reg_write;
         ex_d.mem_to_reg = bus_io.id_mem_to_reg;
         ex_d.dest       = id_dest;
      end
   end

   // Stage registers; MEM and WB advance every cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q             <= ex_d;
         mem_q.mem_read   <= ex_q.mem_read;
         mem_q.mem_write  <= ex_q.mem_write;
         mem_q.reg_write  <= ex_q.reg_write;
         mem_q.mem_to_reg <= ex_q.mem_to_reg;
         mem_q.dest       <= ex_q.dest;
         wb_q.reg_write   <= mem_q.reg_write;
         wb_q.mem_to_reg  <= mem_q.mem_to_reg;
         wb_q.dest        <= mem_q.dest;
      end
   end

   // Forwarding selects; the younger MEM result wins over WB.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (mem_q.reg_write && mem_q.dest == ex_q.rs && mem_q.dest != '0) fwd_a = 2'b10;
      else if (wb_q.reg_write && wb_q.dest == ex_q.rs && wb_q.dest != '0) fwd_a = 2'b01;
      if (mem_q.reg_write && mem_q.dest == ex_q.rt && mem_q.dest != '0) fwd_b = 2'b10;
      else if (wb_q.reg_write && wb_q.dest == ex_q.rt && wb_q.dest != '0) fwd_b = 2'b01;
   end

   assign bus_io.stall          = stall;
   assign bus_io.forward_a      = fwd_a;
   assign bus_io.forward_b      = fwd_b;
   assign bus_io.ex_valid       = ex_q.valid;
   assign bus_io.ex_branch      = ex_q.branch;
   assign bus_io.ex_alu_src     = ex_q.alu_src;
   assign bus_io.ex_jump        = ex_q.jump;
   assign bus_io.ex_alu_op      = ex_q.alu_op;
   assign bus_io.ex_rs          = ex_q.rs;
   assign bus_io.ex_rt          = ex_q.rt;
   assign bus_io.mem_mem_read   = mem_q.mem_read;
   assign bus_io.mem_mem_write  = mem_q.mem_write;
   assign bus_io.mem_reg_write  = mem_q.reg_write;
   assign bus_io.mem_mem_to_reg = mem_q.mem_to_reg;
   assign bus_io.mem_dest       = mem_q.dest;
   assign bus_io.wb_reg_write   = wb_q.reg_write;
   assign bus_io.wb_mem_to_reg  = wb_q.mem_to_reg;
   assign bus_io.wb_dest        = wb_q.dest;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: directed scenarios plus random traffic, every cycle
// compared against a queue-of-instructions reference model.
module tb_ctrl_pipe_hazard;

   localparam int unsigned AW = 5;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   ctrl_pipe_hazard_if #(.REG_AW(AW)) bus ();

   ctrl_pipe_hazard #(.REG_AW(AW), .LINK_REG(31)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus_io  (bus)
   );

   typedef struct {
      bit       valid, reg_dst, branch, mem_to_reg, alu_src, reg_write, flush;
      bit [1:0] jump, mem_read, alu_op, mem_write;
      bit [4:0] rs, rt, rd;
   } in_t;

   typedef struct {
      bit       valid, branch, alu_src, reg_write, mem_to_reg;
      bit [1:0] jump, alu_op, mem_read, mem_write;
      bit [4:0] rs, rt, dest;
   } op_t;

   // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
   op_t pipe [3];
   op_t nop;
   in_t cur;
   int  vectors = 0;
   int  miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic in_t idle();
      in_t i;
      i = '{default: 0};
      return i;
   endfunction

   function automatic in_t rtype(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd);
      in_t i = idle();
      i.valid = 1; i.reg_dst = 1; i.reg_write = 1; i.alu_op = 2'b10;
      i.rs = rs; i.rt = rt; i.rd = rd;
      return i;
   endfunction

   function automatic in_t load(input bit [4:0] rs, input bit [4:0] rt);
      in_t i = idle();
      i.valid = 1; i.mem_read = 2'b01; i.alu_src = 1; i.reg_write = 1; i.mem_to_reg = 1;
      i.rs = rs; i.rt = rt; i.rd = 5'd17;
      return i;
   endfunction

   function automatic in_t rand_in();
      in_t i;
      i.valid      = ($urandom_range(7) != 0);
      i.reg_dst    = 1'($urandom);
      i.branch     = ($urandom_range(5) == 0);
      i.mem_to_reg = 1'($urandom);
      i.alu_src    = 1'($urandom);
      i.reg_write  = 1'($urandom);
      i.flush      = ($urandom_range(7) == 0);
      i.jump       = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
      i.mem_read   = ($urandom_range(2) == 0) ? 2'($urandom) : 2'b00;
      i.alu_op     = 2'($urandom);
      i.mem_write  = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
      i.rs         = 5'($urandom_range(7));
      i.rt         = 5'($urandom_range(7));
      i.rd         = 5'($urandom_range(7));
      return i;
   endfunction

   task automatic drive(input in_t i);
      cur = i;
      bus.id_valid      = i.valid;
      bus.id_reg_dst    = i.reg_dst;
      bus.id_jump       = i.jump;
      bus.id_branch     = i.branch;
      bus.id_mem_read   = i.mem_read;
      bus.id_mem_to_reg = i.mem_to_reg;
      bus.id_alu_op     = i.alu_op;
      bus.id_mem_write  = i.mem_write;
      bus.id_alu_src    = i.alu_src;
      bus.id_reg_write  = i.reg_write;
      bus.id_rs         = i.rs;
      bus.id_rt         = i.rt;
      bus.id_rd         = i.rd;
      bus.ex_flush      = i.flush;
   endtask

   // ---- reference model ----
   function automatic op_t decode(input in_t i);
      op_t o = nop;
      o.valid = 1; o.branch = i.branch; o.alu_src = i.alu_src; o.jump = i.jump;
      o.alu_op = i.alu_op; o.rs = i.rs; o.rt = i.rt; o.mem_read = i.mem_read;
      o.mem_write = i.mem_write; o.mem_to_reg = i.mem_to_reg;
      o.dest = (i.jump == 2'b10) ? 5'd31 : (i.reg_dst ? i.rd : i.rt);
      o.reg_write = (i.reg_write || i.jump == 2'b10) && o.dest != 0;
      return o;
   endfunction

   function automatic bit model_stall();
      bit needs_rt = !cur.alu_src || cur.mem_write != 0 || cur.branch;
      if (!pipe[0].valid || pipe[0].mem_read == 0 || pipe[0].dest == 0) return 0;
      if (!cur.valid || cur.flush) return 0;
      return pipe[0].dest == cur.rs || (needs_rt && pipe[0].dest == cur.rt);
   endfunction

   // Nearest older writer of src supplies the value.
   function automatic bit [1:0] model_fwd(input bit [4:0] src);
      if (src == 0) return 2'b00;
      for (int k = 1; k <= 2; k++)
         if (pipe[k].reg_write && pipe[k].dest == src) return (k == 1) ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   task automatic model_advance();
      bit st = model_stall();
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (cur.flush || st || !cur.valid) ? nop : decode(cur);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) pipe[k] = nop;
   endtask

   task automatic compare_all();
      chk("stall",          bus.stall,          32'(model_stall()));
      chk("forward_a",      bus.forward_a,      32'(model_fwd(pipe[0].rs)));
      chk("forward_b",      bus.forward_b,      32'(model_fwd(pipe[0].rt)));
      chk("ex_valid",       bus.ex_valid,       32'(pipe[0].valid));
      chk("ex_branch",      bus.ex_branch,      32'(pipe[0].branch));
      chk("ex_alu_src",     bus.ex_alu_src,     32'(pipe[0].alu_src));
      chk("ex_jump",        bus.ex_jump,        32'(pipe[0].jump));
      chk("ex_alu_op",      bus.ex_alu_op,      32'(pipe[0].alu_op));
      chk("ex_rs",          bus.ex_rs,          32'(pipe[0].rs));
      chk("ex_rt",          bus.ex_rt,          32'(pipe[0].rt));
      chk("mem_mem_read",   bus.mem_mem_read,   32'(pipe[1].mem_read));
      chk("mem_mem_write",  bus.mem_mem_write,  32'(pipe[1].mem_write));
      chk("mem_reg_write",  bus.mem_reg_write,  32'(pipe[1].reg_write));
      chk("mem_mem_to_reg", bus.mem_mem_to_reg, 32'(pipe[1].mem_to_reg));
      chk("mem_dest",       bus.mem_dest,       32'(pipe[1].dest));
      chk("wb_reg_write",   bus.wb_reg_write,   32'(pipe[2].reg_write));
      chk("wb_mem_to_reg",  bus.wb_mem_to_reg,  32'(pipe[2].mem_to_reg));
      chk("wb_dest",        bus.wb_dest,        32'(pipe[2].dest));
   endtask

   // One clock: compare on the falling edge, then step the model with the DUT.
   task automatic cycle();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   initial begin
      in_t i;
      nop = '{default: 0};
      model_reset();
      drive(idle());
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #2;
      chk("rst ex_valid", bus.ex_valid, 32'd0);
      chk("rst stall", bus.stall, 32'd0);
      chk("rst forward_a", bus.forward_a, 32'd0);
      chk("rst wb_dest", bus.wb_dest, 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // R-type to r5 walks EX, MEM, WB
      drive(rtype(5'd1, 5'd2, 5'd5));
      cycle();
      chk("rtype ex_valid", bus.ex_valid, 32'd1);
      drive(idle());
      cycle();
      chk("rtype mem_dest", bus.mem_dest, 32'd5);
      chk("rtype mem_reg_write", bus.mem_reg_write, 32'd1);
      cycle();
      chk("rtype wb_dest", bus.wb_dest, 32'd5);
      chk("rtype wb_reg_write", bus.wb_reg_write, 32'd1);

      // load-use on rs: one stall, bubble, then WB forwarding
      drive(load(5'd2, 5'd8));
      cycle();
      drive(rtype(5'd8, 5'd9, 5'd10));
      #1 chk("lu stall", bus.stall, 32'd1);
      cycle();
      chk("lu bubble ex_valid", bus.ex_valid, 32'd0);
      chk("lu stall released", bus.stall, 32'd0);
      cycle();
      chk("lu ex_valid", bus.ex_valid, 32'd1);
      chk("lu forward_a", bus.forward_a, 32'd1);

      // two writers of r3, MEM wins
      drive(rtype(5'd1, 5'd2, 5'd3));
      cycle();
      drive(rtype(5'd4, 5'd5, 5'd3));
      cycle();
      drive(rtype(5'd3, 5'd6, 5'd7));
      cycle();
      chk("mem wins forward_a", bus.forward_a, 32'd2);

      // write to r0 is suppressed and never forwarded
      drive(rtype(5'd1, 5'd2, 5'd0));
      cycle();
      drive(rtype(5'd0, 5'd0, 5'd9));
      cycle();
      chk("r0 mem_reg_write", bus.mem_reg_write, 32'd0);
      chk("r0 forward_a", bus.forward_a, 32'd0);
      chk("r0 forward_b", bus.forward_b, 32'd0);

      // flush beats stall
      drive(load(5'd1, 5'd8));
      cycle();
      i = rtype(5'd8, 5'd9, 5'd10);
      i.flush = 1;
      drive(i);
      #1 chk("flush stall", bus.stall, 32'd0);
      cycle();
      chk("flush ex_valid", bus.ex_valid, 32'd0);

      // store dependent on load through rt
      drive(load(5'd1, 5'd7));
      cycle();
      i = idle();
      i.valid = 1; i.mem_write = 2'b01; i.alu_src = 1; i.rs = 5'd2; i.rt = 5'd7;
      drive(i);
      #1 chk("sw stall", bus.stall, 32'd1);
      cycle();
      cycle();

      // jal links to r31 even with reg_write low
      i = idle();
      i.valid = 1; i.jump = 2'b10; i.rt = 5'd4; i.rd = 5'd6;
      drive(i);
      cycle();
      drive(idle());
      cycle();
      cycle();
      chk("jal wb_dest", bus.wb_dest, 32'd31);
      chk("jal wb_reg_write", bus.wb_reg_write, 32'd1);

      // invalid ID with garbage fields leaves nothing behind
      for (int n = 0; n < 4; n++) begin
         i = rand_in();
         i.valid = 0;
         i.flush = 0;
         drive(i);
         cycle();
      end
      chk("inv ex_valid", bus.ex_valid, 32'd0);
      chk("inv ex_rs", bus.ex_rs, 32'd0);
      chk("inv mem_dest", bus.mem_dest, 32'd0);
      chk("inv wb_reg_write", bus.wb_reg_write, 32'd0);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         drive(rand_in());
         cycle();
      end

      // async reset with three writers of r3 in flight
      for (int n = 0; n < 3; n++) begin
         drive(rtype(5'd1, 5'd2, 5'd3));
         cycle();
      end
      #1 reset_n = 1'b0;
      #1;
      chk("arst ex_valid", bus.ex_valid, 32'd0);
      chk("arst mem_reg_write", bus.mem_reg_write, 32'd0);
      chk("arst mem_dest", bus.mem_dest, 32'd0);
      chk("arst wb_reg_write", bus.wb_reg_write, 32'd0);
      chk("arst wb_dest", bus.wb_dest, 32'd0);
      chk("arst forward_a", bus.forward_a, 32'd0);
      chk("arst stall", bus.stall, 32'd0);
      model_reset();
      reset_n = 1'b1;
      drive(rtype(5'd3, 5'd3, 5'd4));
      cycle();
      chk("post-rst ex_valid", bus.ex_valid, 32'd1);
      chk("post-rst forward_a", bus.forward_a, 32'd0);
      chk("post-rst forward_b", bus.forward_b, 32'd0);
      drive(idle());
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
